// File: rtl/fft_pkg.sv
// Shared streaming-FFT definitions: default sample geometry and the complex sample type.
package fft_pkg;

  localparam int FFT_WIDTH  = 16;
  localparam int FFT_DEPTH  = 32;
  localparam int LOG2_DEPTH = $clog2(FFT_DEPTH);
  localparam int FRAME_LEN  = 2 * FFT_DEPTH;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } sample_t;

endpackage

// File: rtl/sdf_delay_buffer.sv
// DEPTH-entry circular delay line holding {re, im}; asynchronous read so the butterfly
// sees the old slot content in the same cycle it is overwritten. Contents are not reset.
module sdf_delay_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [2*WIDTH-1:0]       wr_data,
  output logic [2*WIDTH-1:0]       rd_data
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 SDF butterfly stage: buffers the first half-frame, emits DEPTH sums then DEPTH
// diffs (the diffs leave while the next frame, or a flush, fills the delay line).
module sdf_butterfly_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = FFT_DEPTH,
  parameter int SCALE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     di_en,
  input  logic signed [WIDTH-1:0]  di_re,
  input  logic signed [WIDTH-1:0]  di_im,
  output logic                     do_en,
  output logic signed [WIDTH-1:0]  do_re,
  output logic signed [WIDTH-1:0]  do_im,
  output logic                     do_mul,
  output logic [$clog2(DEPTH)-1:0] tw_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_SLOT  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(2 * DEPTH - 1);

  logic [CW-1:0] count_reg;
  logic          drain_reg;
  logic          phase_b;
  logic [AW-1:0] slot;
  logic          advance;
  logic          frame_end;
  logic          drain_end;
  logic          valid_a;
  logic          valid_b;

  assign phase_b   = count_reg[CW-1];
  assign slot      = count_reg[AW-1:0];
  assign advance   = di_en | drain_reg;
  assign frame_end = advance & (count_reg == LAST_COUNT);
  // A flush with no follow-on frame stops after its last diff so the next frame starts at 0.
  assign drain_end = drain_reg & ~di_en & ~phase_b & (slot == LAST_SLOT);
  assign valid_a   = ~phase_b & drain_reg;
  assign valid_b   = phase_b & di_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      drain_reg <= 1'b0;
    end else if (drain_end) begin
      count_reg <= '0;
      drain_reg <= 1'b0;
    end else if (advance) begin
      count_reg <= count_reg + CW'(1);
      if (frame_end) begin
        drain_reg <= 1'b1;
      end
    end
  end

  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [WIDTH:0] v);
    return (SCALE != 0) ? v[WIDTH:1] : v[WIDTH-1:0];
  endfunction

  logic [2*WIDTH-1:0]      rd_data;
  logic [2*WIDTH-1:0]      wr_data;
  logic                    wr_en;
  logic signed [WIDTH-1:0] din  [2];
  logic signed [WIDTH-1:0] x    [2];
  logic signed [WIDTH-1:0] y    [2];
  logic signed [WIDTH-1:0] sum  [2];
  logic signed [WIDTH-1:0] diff [2];

  assign din[0] = di_re;
  assign din[1] = di_im;
  assign x[0]   = rd_data[2*WIDTH-1:WIDTH];
  assign x[1]   = rd_data[WIDTH-1:0];

  // Lane 0 is the real component, lane 1 the imaginary; both widen by one bit before narrowing.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign y[gi]    = di_en ? din[gi] : '0;
      assign sum[gi]  = narrow({x[gi][WIDTH-1], x[gi]} + {y[gi][WIDTH-1], y[gi]});
      assign diff[gi] = narrow({x[gi][WIDTH-1], x[gi]} - {y[gi][WIDTH-1], y[gi]});
    end
  endgenerate

  assign wr_en   = phase_b ? di_en : advance;
  assign wr_data = phase_b ? {diff[0], diff[1]} : {y[0], y[1]};

  sdf_delay_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_delay (
    .clock   (clock),
    .wr_en   (wr_en),
    .addr    (slot),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en   <= 1'b0;
      do_re   <= '0;
      do_im   <= '0;
      do_mul  <= 1'b0;
      tw_addr <= '0;
    end else begin
      do_en <= valid_a | valid_b;
      if (valid_b) begin
        do_re   <= sum[0];
        do_im   <= sum[1];
        do_mul  <= 1'b0;
        tw_addr <= '0;
      end else if (valid_a) begin
        do_re   <= x[0];
        do_im   <= x[1];
        do_mul  <= 1'b1;
        tw_addr <= slot;
      end else begin
        do_re   <= '0;
        do_im   <= '0;
        do_mul  <= 1'b0;
        tw_addr <= '0;
      end
    end
  end

endmodule
